// File: rtl/controller_responder_if.sv
// rtl/controller_responder_if.sv - console-side pad signals bundle; CONTROLLER_RESPONDER_STATS_EN adds stats outputs
interface controller_responder_if #(
  parameter int NUM_BITS = 8
);
  logic                latch_i;
  logic                ctrl_clk_i;
  logic [NUM_BITS-1:0] buttons_i;
  logic                serial_no;
  logic                busy_o;
`ifdef CONTROLLER_RESPONDER_STATS_EN
  logic [7:0]          latch_count_o;
  logic                overrun_o;
`endif

  modport master (
    output latch_i, ctrl_clk_i, buttons_i,
`ifdef CONTROLLER_RESPONDER_STATS_EN
    input  latch_count_o, overrun_o,
`endif
    input  serial_no, busy_o
  );

  modport slave (
    input  latch_i, ctrl_clk_i, buttons_i,
`ifdef CONTROLLER_RESPONDER_STATS_EN
    output latch_count_o, overrun_o,
`endif
    output serial_no, busy_o
  );
endinterface

// File: rtl/controller_responder.sv
// rtl/controller_responder.sv - emulates one NES-style serial game pad on the console side
// Optional latch counter / overrun flag enabled by CONTROLLER_RESPONDER_STATS_EN.
module controller_responder #(
  parameter int   NUM_BITS    = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_BIT    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  controller_responder_if.slave  bus
);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 r_state, w_state_next;
  logic [NUM_BITS-1:0]    r_sr, w_sr_next;
  logic [CW-1:0]          r_cnt, w_cnt_next;
  logic [SYNC_STAGES-1:0] r_latch_sync, r_ctrl_sync;
  logic                   r_latch_d, r_ctrl_d;
  logic                   w_latch_s, w_ctrl_s;
  logic                   w_latch_rise, w_latch_fall, w_ctrl_rise;

  assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
  assign w_ctrl_s     = r_ctrl_sync[SYNC_STAGES-1];
  assign w_latch_rise = w_latch_s & ~r_latch_d;
  assign w_latch_fall = ~w_latch_s & r_latch_d;
  assign w_ctrl_rise  = w_ctrl_s & ~r_ctrl_d;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_latch_sync <= '0;
      r_ctrl_sync  <= '0;
      r_latch_d    <= 1'b0;
      r_ctrl_d     <= 1'b0;
      r_state      <= IDLE;
      r_sr         <= {NUM_BITS{~FILL_BIT}};
      r_cnt        <= '0;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], bus.latch_i};
      r_ctrl_sync  <= {r_ctrl_sync[SYNC_STAGES-2:0], bus.ctrl_clk_i};
      r_latch_d    <= w_latch_s;
      r_ctrl_d     <= w_ctrl_s;
      r_state      <= w_state_next;
      r_sr         <= w_sr_next;
      r_cnt        <= w_cnt_next;
    end
  end

  // A latch rise always takes priority over a coincident console clock edge.
  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_latch_s) begin
          w_state_next = LOAD;
          w_sr_next    = bus.buttons_i;
          w_cnt_next   = '0;
        end
      end
      LOAD: begin
        w_sr_next  = bus.buttons_i;
        w_cnt_next = '0;
        if (w_latch_fall) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_latch_rise) begin
          w_state_next = LOAD;
          w_sr_next    = bus.buttons_i;
          w_cnt_next   = '0;
        end else if (w_ctrl_rise) begin
          w_sr_next  = {~FILL_BIT, r_sr[NUM_BITS-1:1]};
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) w_state_next = DONE;
        end
      end
      DONE: begin
        if (w_latch_rise) begin
          w_state_next = LOAD;
          w_sr_next    = bus.buttons_i;
          w_cnt_next   = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.serial_no = (r_state == DONE) ? FILL_BIT : ~r_sr[0];
  assign bus.busy_o    = (r_state == LOAD) || (r_state == SHIFT);

`ifdef CONTROLLER_RESPONDER_STATS_EN
  logic [7:0] r_latch_count;
  logic       r_overrun;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_latch_count <= '0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_latch_rise) r_latch_count <= r_latch_count + 8'd1;
      if (w_latch_rise)
        r_overrun <= 1'b0;
      else if (r_state == DONE && w_ctrl_rise)
        r_overrun <= 1'b1;
    end
  end

  assign bus.latch_count_o = r_latch_count;
  assign bus.overrun_o     = r_overrun;
`endif
endmodule

// File: tb/tb_controller_responder.sv
// tb/tb_controller_responder.sv - directed self-checking bench for controller_responder
module tb_controller_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic toggle_en;
  int   checks;
  int   failures;

  always #5 clk = ~clk;

  controller_responder_if #(.NUM_BITS(8)) bus ();

  controller_responder dut (
    .clk    (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (toggle_en) bus.buttons_i = ~bus.buttons_i;
    end
  endtask

  task automatic latch_pulse();
    bus.latch_i = 1'b1;
    tick(6);
    bus.latch_i = 1'b0;
    tick(6);
  endtask

  task automatic ctrl_edge();
    bus.ctrl_clk_i = 1'b1;
    tick(4);
    bus.ctrl_clk_i = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++;
    if (bus.serial_no !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs serial=%b busy=%b want serial=1 busy=0", bus.serial_no, bus.busy_o);
    end
    rst_n = 1'b1;
    tick(6);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_release busy=%b want 0", bus.busy_o);
    end
    bus.latch_i = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL release_latch_high busy=%b want 1", bus.busy_o);
    end
    bus.latch_i = 1'b0;
    tick(6);
  endtask

  task automatic test_reset_mid_shift();
    bus.buttons_i = 8'h03;
    latch_pulse();
    ctrl_edge();
    checks++;
    if (bus.serial_no !== 1'b0 || bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_shift serial=%b busy=%b want serial=0 busy=1", bus.serial_no, bus.busy_o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.serial_no !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset serial=%b busy=%b want serial=1 busy=0", bus.serial_no, bus.busy_o);
    end
    tick(2);
    rst_n = 1'b1;
    ctrl_edge();
    checks++;
    if (bus.serial_no !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_mid_reset serial=%b busy=%b want serial=1 busy=0", bus.serial_no, bus.busy_o);
    end
  endtask

  task automatic test_report();
    logic [7:0] exp_seq;
    exp_seq = 8'b0101_1010;
    bus.buttons_i = 8'b1010_0101;
    latch_pulse();
    checks++;
    if (bus.serial_no !== exp_seq[0] || bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL report_bit0 serial=%b busy=%b want serial=%b busy=1", bus.serial_no, bus.busy_o, exp_seq[0]);
    end
    bus.ctrl_clk_i = 1'b1;
    tick(2);
    checks++;
    if (bus.serial_no !== exp_seq[0]) begin
      failures++;
      $display("FAIL latency_early serial=%b want %b", bus.serial_no, exp_seq[0]);
    end
    tick(1);
    checks++;
    if (bus.serial_no !== exp_seq[1]) begin
      failures++;
      $display("FAIL latency_3clk serial=%b want %b", bus.serial_no, exp_seq[1]);
    end
    tick(1);
    bus.ctrl_clk_i = 1'b0;
    tick(4);
    for (int k = 2; k < 8; k++) begin
      ctrl_edge();
      checks++;
      if (bus.serial_no !== exp_seq[k] || bus.busy_o !== 1'b1) begin
        failures++;
        $display("FAIL report_bit%0d serial=%b busy=%b want serial=%b busy=1", k, bus.serial_no, bus.busy_o, exp_seq[k]);
      end
    end
    ctrl_edge();
    checks++;
    if (bus.serial_no !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL report_done serial=%b busy=%b want serial=1 busy=0", bus.serial_no, bus.busy_o);
    end
  endtask

  task automatic test_overrun();
    for (int k = 9; k <= 12; k++) begin
      ctrl_edge();
      checks++;
      if (bus.serial_no !== 1'b1 || bus.busy_o !== 1'b0) begin
        failures++;
        $display("FAIL extra_edge%0d serial=%b busy=%b want serial=1 busy=0", k, bus.serial_no, bus.busy_o);
      end
    end
`ifdef CONTROLLER_RESPONDER_STATS_EN
    checks++;
    if (bus.overrun_o !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b want 1", bus.overrun_o);
    end
    latch_pulse();
    checks++;
    if (bus.overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b want 0", bus.overrun_o);
    end
`endif
  endtask

  task automatic test_reload();
    bus.buttons_i = 8'b1010_0101;
    latch_pulse();
    repeat (3) ctrl_edge();
    checks++;
    if (bus.serial_no !== 1'b1) begin
      failures++;
      $display("FAIL before_reload serial=%b want 1", bus.serial_no);
    end
    bus.buttons_i = 8'hFF;
    latch_pulse();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.serial_no !== 1'b0 || bus.busy_o !== 1'b1) begin
        failures++;
        $display("FAIL reload_bit%0d serial=%b busy=%b want serial=0 busy=1", k, bus.serial_no, bus.busy_o);
      end
      ctrl_edge();
    end
    checks++;
    if (bus.serial_no !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reload_done serial=%b busy=%b want serial=1 busy=0", bus.serial_no, bus.busy_o);
    end
  endtask

  task automatic test_simultaneous();
    bus.buttons_i = 8'h02;
    latch_pulse();
    ctrl_edge();
    checks++;
    if (bus.serial_no !== 1'b0) begin
      failures++;
      $display("FAIL simul_pre serial=%b want 0", bus.serial_no);
    end
    bus.buttons_i = 8'h01;
    bus.latch_i = 1'b1;
    bus.ctrl_clk_i = 1'b1;
    tick(6);
    bus.latch_i = 1'b0;
    bus.ctrl_clk_i = 1'b0;
    tick(6);
    checks++;
    if (bus.serial_no !== 1'b0 || bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL simul_first_bit serial=%b busy=%b want serial=0 busy=1", bus.serial_no, bus.busy_o);
    end
    ctrl_edge();
    checks++;
    if (bus.serial_no !== 1'b1) begin
      failures++;
      $display("FAIL simul_second_bit serial=%b want 1", bus.serial_no);
    end
  endtask

  task automatic test_buttons_toggle();
    logic [7:0] exp_seq;
    exp_seq = 8'b1100_0011;
    bus.buttons_i = 8'h3C;
    latch_pulse();
    toggle_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.serial_no !== exp_seq[k]) begin
        failures++;
        $display("FAIL toggle_bit%0d serial=%b want %b", k, bus.serial_no, exp_seq[k]);
      end
      ctrl_edge();
    end
    toggle_en = 1'b0;
    checks++;
    if (bus.serial_no !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL toggle_done serial=%b busy=%b want serial=1 busy=0", bus.serial_no, bus.busy_o);
    end
  endtask

`ifdef CONTROLLER_RESPONDER_STATS_EN
  task automatic test_latch_wrap();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    checks++;
    if (bus.latch_count_o !== 8'd0 || bus.overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL stats_reset count=%0d overrun=%b want 0 0", bus.latch_count_o, bus.overrun_o);
    end
    latch_pulse();
    checks++;
    if (bus.latch_count_o !== 8'd1) begin
      failures++;
      $display("FAIL latch_count_1 got=%0d want 1", bus.latch_count_o);
    end
    repeat (255) begin
      bus.latch_i = 1'b1;
      tick(4);
      bus.latch_i = 1'b0;
      tick(4);
    end
    tick(4);
    checks++;
    if (bus.latch_count_o !== 8'd0) begin
      failures++;
      $display("FAIL latch_count_wrap got=%0d want 0", bus.latch_count_o);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    toggle_en = 1'b0;
    rst_n = 1'b0;
    bus.latch_i = 1'b0;
    bus.ctrl_clk_i = 1'b0;
    bus.buttons_i = 8'h00;
    test_reset();
    test_reset_mid_shift();
    test_report();
    test_overrun();
    test_reload();
    test_simultaneous();
    test_buttons_toggle();
`ifdef CONTROLLER_RESPONDER_STATS_EN
    test_latch_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
